// File: rtl/ipf_result_writer_pkg.sv
// ipf_result_writer_pkg
//   Shared constants and encodings for the IPF result writer slice.
//   - Width constants for raw results, stored pixels, addresses and the
//     write counter.
//   - mode_e: filter modes that select the raw-to-pixel conversion.
//   - state_e: writer FSM states.
package ipf_result_writer_pkg;

    localparam int IN_WIDTH   = 9;
    localparam int PIX_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH  = 17;

    typedef enum logic [1:0] {
        MODE_DIFF   = 2'd0,
        MODE_SHARP  = 2'd1,
        MODE_SMOOTH = 2'd2,
        MODE_RAW    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ipf_result_writer_fifo.sv
// ipf_wr_fifo
//   Small synchronous FIFO holding {addr, pixel} entries for the result writer.
//   Head entry is presented straight from registered storage. A push while
//   full is taken only if a pop happens on the same edge.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (empties FIFO, clears storage)
//   push   in   write din at tail
//   din    in   entry to write
//   pop    in   drop head entry
//   dout   out  head entry (valid when !empty)
//   full   out  all Depth entries occupied
//   empty  out  no entries
module ipf_wr_fifo #(
    parameter int Width = 24,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0]   mem_q [Depth];
    logic [Width-1:0]   mem_d [Depth];
    logic               do_push;
    logic               do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign dout  = mem_q[rd_ptr_q[PtrW-1:0]];

    // When full, the tail slot is the head slot; the pop reads the old value
    // through dout before the edge, so overwriting it on that edge is safe.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ipf_result_writer.sv
// ipf_result_writer
//   Converts raw IPF filter results to stored pixels according to the filter
//   mode, queues {addr, pixel} in a small FIFO and writes them to the result
//   SRAM over a req/ready port. Signals done once IPF has finished and every
//   accepted pixel has been written.
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   mode        in   filter mode, sampled with each ipf_valid pixel
//   ipf_valid   in   raw result present (no backpressure)
//   ipf_addr    in   destination address of the result
//   ipf_data    in   raw result
//   ipf_finish  in   IPF finished (level)
//   res_wr      out  SRAM write request
//   res_addr    out  write address
//   res_data    out  write data
//   res_ready   in   SRAM accepts the write this cycle
//   wr_count    out  pixels written since reset (saturating)
//   overflow    out  sticky: a pixel was dropped on a full FIFO
//   done        out  sticky: all work complete
module ipf_result_writer
    import ipf_result_writer_pkg::*;
#(
    parameter int In_Width   = IN_WIDTH,
    parameter int Pix_Width  = PIX_WIDTH,
    parameter int Addr_Width = ADDR_WIDTH,
    parameter int FIFO_Depth = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  ipf_valid,
    input  logic [Addr_Width-1:0] ipf_addr,
    input  logic [In_Width-1:0]   ipf_data,
    input  logic                  ipf_finish,
    output logic                  res_wr,
    output logic [Addr_Width-1:0] res_addr,
    output logic [Pix_Width-1:0]  res_data,
    input  logic                  res_ready,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  overflow,
    output logic                  done
);

    localparam int EntW = Addr_Width + Pix_Width;
    localparam logic signed [In_Width:0] BIAS      = (In_Width+1)'(2**(Pix_Width-1));
    localparam logic signed [In_Width:0] PIX_MAX_S = (In_Width+1)'(2**Pix_Width - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wr_count_q, wr_count_d;
    logic                   overflow_q, overflow_d;

    logic signed [In_Width:0] v_s;
    logic signed [In_Width:0] biased;
    logic [Pix_Width-1:0]   pix;

    logic                   push_req;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [EntW-1:0]        fifo_dout;

    // Raw-to-pixel conversion. v_s is the sign-extended raw result; the
    // difference mode recentres it around mid-grey before clamping.
    always_comb begin
        v_s    = $signed({ipf_data[In_Width-1], ipf_data});
        biased = v_s + BIAS;
        pix    = ipf_data[Pix_Width-1:0];
        case (mode_e'(mode))
            MODE_DIFF: begin
                if (biased[In_Width])
                    pix = '0;
                else if (biased > PIX_MAX_S)
                    pix = '1;
                else
                    pix = biased[Pix_Width-1:0];
            end
            MODE_SHARP:  pix = v_s[In_Width] ? '0 : ipf_data[Pix_Width-1:0];
            MODE_SMOOTH: pix = (|ipf_data[In_Width-1:Pix_Width]) ? '1 : ipf_data[Pix_Width-1:0];
            default:     pix = ipf_data[Pix_Width-1:0];
        endcase
    end

    // Pop only acts on entries already stored, so a push into an empty FIFO
    // never pops on the same edge.
    assign push_req = ipf_valid && (state_q != DONE);
    assign pop      = !fifo_empty && res_ready;
    assign drop     = push_req && fifo_full && !pop;

    ipf_wr_fifo #(
        .Width (EntW),
        .Depth (FIFO_Depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   ({ipf_addr, pix}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        overflow_d = overflow_q | drop;

        if (pop && (wr_count_q != '1))
            wr_count_d = wr_count_q + CNT_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (ipf_finish)
                    state_d = DRAIN;
                else if (ipf_valid)
                    state_d = RUN;
            end
            RUN: begin
                if (ipf_finish)
                    state_d = DRAIN;
            end
            // IPF's output pipeline lags its finish, so keep accepting here
            // and only retire once nothing is queued or arriving.
            DRAIN: begin
                if (fifo_empty && !push_req)
                    state_d = DONE;
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            overflow_q <= overflow_d;
        end
    end

    assign res_wr               = !fifo_empty;
    assign {res_addr, res_data} = fifo_dout;
    assign wr_count             = wr_count_q;
    assign overflow             = overflow_q;
    assign done                 = (state_q == DONE);

endmodule

// File: tb/tb_ipf_result_writer.sv
// tb_ipf_result_writer
//   Directed plus randomized bench for ipf_result_writer. A queue-based
//   reference model tracks the pending writes, counter, overflow and done
//   flags cycle by cycle; outputs are compared every cycle, with extra
//   constant checks at the interesting points.
module tb_ipf_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        ipf_valid = 1'b0;
    logic [15:0] ipf_addr = '0;
    logic [8:0]  ipf_data = '0;
    logic        ipf_finish = 1'b0;
    logic        res_ready = 1'b0;
    logic        res_wr;
    logic [15:0] res_addr;
    logic [7:0]  res_data;
    logic [16:0] wr_count;
    logic        overflow;
    logic        done;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int addr;
        int pix;
    } ent_t;

    ent_t mq[$];
    int   m_cnt = 0;
    bit   m_ovf = 0;
    bit   m_drain = 0;
    bit   m_done = 0;
    int   base;

    logic [1:0] cm [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [8:0] cd [8] = '{9'h181, 9'h07F, 9'h000, 9'h1F0, 9'h0C8, 9'h100, 9'h0AB, 9'h1AB};
    int         ce [8] = '{1, 255, 128, 0, 200, 255, 171, 171};

    ipf_result_writer dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .ipf_valid  (ipf_valid),
        .ipf_addr   (ipf_addr),
        .ipf_data   (ipf_data),
        .ipf_finish (ipf_finish),
        .res_wr     (res_wr),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .wr_count   (wr_count),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Pixel value a raw result should become, from the mode rules.
    function automatic int ref_conv(int md, int d);
        int s;
        int t;
        s = (d >= 256) ? d - 512 : d;
        case (md)
            0: begin
                t = s + 128;
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                return t;
            end
            1: return (s < 0) ? 0 : s;
            2: return (d > 255) ? 255 : d;
            default: return d % 256;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare outputs to the model, advance the model using the inputs of
    // this cycle, then step one clock.
    task automatic tick();
        int   sz;
        bit   pop;
        bit   pushr;
        ent_t e;
        sz = mq.size();
        chk("res_wr", 32'(res_wr), 32'(sz > 0));
        if (sz > 0) begin
            chk("res_addr", 32'(res_addr), 32'(mq[0].addr));
            chk("res_data", 32'(res_data), 32'(mq[0].pix));
        end
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("done", 32'(done), 32'(m_done));
        if (rst) begin
            mq.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_drain = 0;
            m_done = 0;
        end else begin
            pop   = (sz > 0) && res_ready;
            pushr = ipf_valid && !m_done;
            if (!m_done) begin
                if (m_drain) begin
                    if (sz == 0 && !pushr) m_done = 1;
                end else if (ipf_finish) begin
                    m_drain = 1;
                end
            end
            if (pop) begin
                void'(mq.pop_front());
                if (m_cnt < 131071) m_cnt++;
            end
            if (pushr) begin
                if (sz < 4 || pop) begin
                    e.addr = int'(ipf_addr);
                    e.pix  = ref_conv(int'(mode), int'(ipf_data));
                    mq.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic v);
        ipf_valid = v;
        mode      = 2'($urandom_range(0, 3));
        ipf_addr  = 16'($urandom);
        ipf_data  = 9'($urandom);
    endtask

    initial begin
        // Power-up reset, unchecked until the DUT has seen an edge in reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_res_wr", 32'(res_wr), 32'd0);
        chk("reset_wr_count", 32'(wr_count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // Conversion vectors, each written alone; also checks N+1 latency.
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ipf_valid = 1'b1;
            mode      = cm[i];
            ipf_addr  = 16'(i + 16'h0100);
            ipf_data  = cd[i];
            tick();
            ipf_valid = 1'b0;
            chk($sformatf("conv%0d_wr", i), 32'(res_wr), 32'd1);
            chk($sformatf("conv%0d_data", i), 32'(res_data), 32'(ce[i]));
            tick();
        end

        // Streaming: 10 back-to-back pixels with the SRAM always ready.
        for (int i = 0; i < 10; i++) begin
            set_pix(1'b1);
            tick();
            if (i == 0) chk("stream_first_wr", 32'(res_wr), 32'd1);
        end
        ipf_valid = 1'b0;
        repeat (3) tick();
        chk("stream_count", 32'(wr_count), 32'd18);
        chk("stream_overflow", 32'(overflow), 32'd0);

        // Backpressure: fill 4, 5th rides a pop, 6th is dropped.
        res_ready = 1'b0;
        repeat (4) begin
            set_pix(1'b1);
            tick();
        end
        chk("bp_full_wr", 32'(res_wr), 32'd1);
        res_ready = 1'b1;
        set_pix(1'b1);
        tick();
        chk("bp_5th_overflow", 32'(overflow), 32'd0);
        res_ready = 1'b0;
        set_pix(1'b1);
        tick();
        ipf_valid = 1'b0;
        chk("bp_6th_overflow", 32'(overflow), 32'd1);
        res_ready = 1'b1;
        repeat (6) tick();
        chk("bp_count", 32'(wr_count), 32'd23);
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Random traffic with random stalls; head must hold while stalled.
        repeat (300) begin
            set_pix(1'($urandom_range(0, 1)));
            res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        ipf_valid = 1'b0;
        res_ready = 1'b1;
        repeat (6) tick();

        // Drain/done: 3 queued, finish, 2 more arrive, done after the 5th write.
        res_ready = 1'b0;
        base = m_cnt;
        repeat (3) begin
            set_pix(1'b1);
            tick();
        end
        ipf_finish = 1'b1;
        res_ready  = 1'b1;
        repeat (2) begin
            set_pix(1'b1);
            tick();
        end
        ipf_valid = 1'b0;
        repeat (2) tick();
        chk("drain_not_done_4", 32'(done), 32'd0);
        tick();
        chk("drain_not_done_5", 32'(done), 32'd0);
        chk("drain_count5", 32'(wr_count), 32'(base + 5));
        tick();
        chk("drain_done", 32'(done), 32'd1);
        repeat (3) begin
            set_pix(1'b1);
            tick();
        end
        ipf_valid = 1'b0;
        chk("done_no_wr", 32'(res_wr), 32'd0);
        chk("done_count_hold", 32'(wr_count), 32'(base + 5));
        tick();

        // Reset mid-operation with 3 entries queued behind a stalled SRAM.
        ipf_finish = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_ready = 1'b0;
        repeat (3) begin
            set_pix(1'b1);
            tick();
        end
        ipf_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_res_wr", 32'(res_wr), 32'd0);
        chk("midrst_count", 32'(wr_count), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        res_ready = 1'b1;
        repeat (2) begin
            set_pix(1'b1);
            tick();
        end
        ipf_valid = 1'b0;
        repeat (3) tick();
        chk("post_rst_count", 32'(wr_count), 32'd2);
        chk("post_rst_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
